wr_ctrl_burst: RTL and testbench

Avalon-MM burst write master that moves one packet from a show-ahead FIFO into memory. It sits between the packet capture FIFO and the memory interconnect. On a start request it computes the packet length from byte offsets and issues one or more Avalon bursts at the given address. It pops one FIFO word per accepted beat and signals readiness when idle.

---
 rtl/wr_ctrl_burst.sv | 79 +++++++
 tb/tb_wr_ctrl_burst.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/wr_ctrl_burst.sv
// wr_ctrl_burst: Avalon-MM burst write master fed by a show-ahead FIFO; define WR_CTRL_BURST_SPLIT_EN to split packets into MAX_BURST-beat bursts.
module wr_ctrl_burst #(
  parameter int MAX_BURST = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_ctrl,
  input  logic        empty,
  input  logic [31:0] control,
  input  logic [31:0] pkt_begin,
  input  logic [31:0] pkt_end,
  input  logic [31:0] write_address,
  input  logic [31:0] fifo_out,
  output logic        rd_from_fifo,
  output logic        wr_ctrl_rdy,
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic        write,
  output logic [15:0] burstcount,
  input  logic        waitrequest
);
`ifdef WR_CTRL_BURST_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, BURST, DONE} state_t;
  state_t state, state_n;
  logic [31:0] rem;
  logic [15:0] beats;
  logic [15:0] bc_n;
  logic [31:0] words;
  logic        accept;
  logic        unused;
  assign unused = ^control;
  assign words = pkt_end > pkt_begin ? (pkt_end - pkt_begin + 32'd3) >> 2 : '0;
  assign bc_n = SPLIT && rem > 32'(MAX_BURST) ? 16'(MAX_BURST) : rem[15:0];
  assign write = state == BURST && !empty;
  assign accept = write && !waitrequest;
  assign rd_from_fifo = accept;
  assign writedata = state == BURST ? fifo_out : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = wr_ctrl ? LOAD : IDLE;
      LOAD:    state_n = rem == '0 ? DONE : BURST;
      BURST:   if (accept && beats == 16'd1) state_n = rem == 32'd1 ? DONE : LOAD;
      DONE:    state_n = wr_ctrl ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // address doubles as the running destination pointer; it only moves between bursts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wr_ctrl_rdy <= 1'b0;
      address     <= '0;
      burstcount  <= '0;
      beats       <= '0;
      rem         <= '0;
    end else begin
      state       <= state_n;
      wr_ctrl_rdy <= state_n == IDLE;
      if (state == IDLE && wr_ctrl) begin
        address <= write_address;
        rem     <= words;
      end
      if (state == LOAD && rem != '0) begin
        burstcount <= bc_n;
        beats      <= bc_n;
      end
      if (accept) begin
        beats <= beats - 16'd1;
        rem   <= rem - 32'd1;
        if (beats == 16'd1) address <= address + 32'({burstcount, 2'b00});
      end
    end
  end
endmodule

// File: tb/tb_wr_ctrl_burst.sv
// tb_wr_ctrl_burst: table-driven packet vectors plus reset sequences for wr_ctrl_burst.
module tb_wr_ctrl_burst;
  localparam int MB = 128;
`ifdef WR_CTRL_BURST_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  typedef struct {
    logic [31:0] b, e, a;
    int w, ea, wa, wl;
    bit drop;
  } vec_t;
  logic clk = 0, reset = 0, wr_ctrl = 0, empty = 0, waitrequest = 0;
  logic [31:0] control = 32'hdead_beef, pkt_begin = 0, pkt_end = 0, write_address = 0, fifo_out;
  logic rd_from_fifo, wr_ctrl_rdy, write;
  logic [31:0] address, writedata;
  logic [15:0] burstcount;
  int rd_ptr = 0, nbeats = 0, npops = 0, bad_d = 0, bad_a = 0;
  int cur_b0 = 0, cur_start = 0, cur_words = 0;
  logic [31:0] cur_a = 0;
  int ncmp = 0, nfail = 0;
  vec_t vecs[9];

  wr_ctrl_burst #(.MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .wr_ctrl(wr_ctrl), .empty(empty), .control(control),
    .pkt_begin(pkt_begin), .pkt_end(pkt_end), .write_address(write_address), .fifo_out(fifo_out),
    .rd_from_fifo(rd_from_fifo), .wr_ctrl_rdy(wr_ctrl_rdy), .address(address), .writedata(writedata),
    .write(write), .burstcount(burstcount), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;
  assign fifo_out = 32'd10 + 32'(rd_ptr);
  always @(posedge clk) if (rd_from_fifo) rd_ptr <= rd_ptr + 1;

  always @(negedge clk) begin
    int i, k, ebc;
    i = nbeats - cur_b0;
    k = SPLIT ? i / MB : 0;
    ebc = SPLIT ? ((cur_words - k * MB) < MB ? cur_words - k * MB : MB) : cur_words;
    if (write && !waitrequest) begin
      if (writedata !== 32'(10 + cur_start + i)) bad_d++;
      if (address !== cur_a + 32'(k * MB * 4) || burstcount !== 16'(ebc)) bad_a++;
      nbeats++;
    end
    if (rd_from_fifo) npops++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_ctl"}, {61'd0, wr_ctrl_rdy, write, rd_from_fifo}, 64'd0);
    chk({tag, "_bus"}, {address, burstcount, 16'd0}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, writedata}, 64'd0);
  endtask

  task automatic start_pkt(input vec_t v);
    cur_a = v.a; cur_words = v.w; cur_start = rd_ptr; cur_b0 = nbeats;
    pkt_begin = v.b; pkt_end = v.e; write_address = v.a;
    wr_ctrl = 1; empty = 0; waitrequest = 0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int p0, bd0, ba0, cyc, post, nb, wcnt;
    bit edone;
    chk({tag, "_rdy_idle"}, {63'd0, wr_ctrl_rdy}, 64'd1);
    p0 = npops; bd0 = bad_d; ba0 = bad_a;
    start_pkt(v);
    cyc = 0; post = 0; wcnt = 0; edone = 0;
    while (cyc < 2000 && post < 4) begin
      @(posedge clk); #1;
      cyc++;
      nb = nbeats - cur_b0;
      empty = 0; waitrequest = 0;
      if (cyc == 1) chk({tag, "_rdy_fall"}, {63'd0, wr_ctrl_rdy}, 64'd0);
      if (v.drop && nb >= 1) wr_ctrl = 0;
      if (v.ea >= 0 && !edone && nb == v.ea) begin
        empty = 1; edone = 1;
        @(negedge clk);
        chk({tag, "_empty_stall"}, {62'd0, write, rd_from_fifo}, 64'd0);
      end else if (v.wa >= 0 && wcnt < v.wl && nb == v.wa) begin
        waitrequest = 1; wcnt++;
        @(negedge clk);
        chk({tag, "_wait_hold"}, {30'd0, write, rd_from_fifo, writedata}, {30'd0, 2'b10, 32'(10 + cur_start + nb)});
      end
      if (nbeats - cur_b0 >= v.w) post++;
    end
    chk({tag, "_in_time"}, {63'd0, cyc < 2000}, 64'd1);
    chk({tag, "_beats"}, 64'(nbeats - cur_b0), 64'(v.w));
    chk({tag, "_pops"}, 64'(npops - p0), 64'(v.w));
    chk({tag, "_data_bad"}, 64'(bad_d - bd0), 64'd0);
    chk({tag, "_addr_bc_bad"}, 64'(bad_a - ba0), 64'd0);
    chk({tag, "_write_done"}, {63'd0, write}, 64'd0);
    if (!v.drop) chk({tag, "_rdy_done"}, {63'd0, wr_ctrl_rdy}, 64'd0);
    wr_ctrl = 0;
    @(posedge clk); #1;
    chk({tag, "_rdy_back"}, {63'd0, wr_ctrl_rdy}, 64'd1);
  endtask

  initial begin
    int guard;
    vecs[0] = '{32'd0,  32'd32,   32'h8000, 8,   -1, -1, 0, 1'b0};
    vecs[1] = '{32'd0,  32'd32,   32'h8000, 8,    4, -1, 0, 1'b0};
    vecs[2] = '{32'd0,  32'd32,   32'h8000, 8,   -1,  3, 2, 1'b0};
    vecs[3] = '{32'd0,  32'd0,    32'h0100, 0,   -1, -1, 0, 1'b0};
    vecs[4] = '{32'd0,  32'd1200, 32'h8000, 300, -1, -1, 0, 1'b0};
    vecs[5] = '{32'd5,  32'd10,   32'h0040, 2,   -1, -1, 0, 1'b0};
    vecs[6] = '{32'd40, 32'd8,    32'h0080, 0,   -1, -1, 0, 1'b0};
    vecs[7] = '{32'd0,  32'd512,  32'h4000, 128, -1, -1, 0, 1'b0};
    vecs[8] = '{32'd0,  32'd516,  32'h1000, 129, 60, 127, 1, 1'b1};
    #3;
    chk_zero_outs("reset");
    @(posedge clk); #1;
    reset = 1;
    chk({"rdy_pre_edge"}, {63'd0, wr_ctrl_rdy}, 64'd0);
    @(posedge clk); #1;
    chk({"rdy_post_reset"}, {63'd0, wr_ctrl_rdy}, 64'd1);
    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    start_pkt('{32'd0, 32'd32, 32'h2000, 8, -1, -1, 0, 1'b0});
    guard = 0;
    while (nbeats - cur_b0 < 3 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("midrst_reach", {63'd0, guard < 50}, 64'd1);
    reset = 0;
    #1;
    chk_zero_outs("midrst");
    guard = npops;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_pop", 64'(npops - guard), 64'd0);
    wr_ctrl = 0;
    reset = 1;
    @(posedge clk); #1;
    chk("midrst_rdy", {63'd0, wr_ctrl_rdy}, 64'd1);
    run_vec(vecs[0], "after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
